// File: rtl/fpu_mds_pkg.sv
// Shared codes, state encoding and constants for the FPU mul/div/sqrt controller.
package fpu_mds_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_SQRT = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    localparam logic [1:0] OUT_MUL  = 2'b00;
    localparam logic [1:0] OUT_DIV  = 2'b01;
    localparam logic [1:0] OUT_SQRT = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL      = 3'd1,
        MUL_OUT  = 3'd2,
        DIV      = 3'd3,
        DIV_OUT  = 3'd4,
        SQRT     = 3'd5,
        SQRT_OUT = 3'd6
    } state_e;

    // Canonical quiet NaN {0, all-ones exponent, fraction MSB set}, right-aligned in 64 bits.
    function automatic logic [63:0] canon_nan(input int unsigned exp_w, input int unsigned sig_w);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < exp_w; i++) begin
            r[sig_w + i] = 1'b1;
        end
        r[sig_w - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fpu_class_unit.sv
// Classifies one IEEE-754 operand as zero, infinity, NaN or signalling NaN.
module fpu_class_unit
    import fpu_mds_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned SIG_W = 23
) (
    input  logic [EXP_W-1:0] exponent,
    input  logic [SIG_W-1:0] fraction,
    output logic             zero,
    output logic             inf,
    output logic             nan,
    output logic             snan
);

    // Pure decode of exponent/fraction fields.
    always_comb begin
        zero = (exponent == '0) && (fraction == '0);
        inf  = (exponent == '1) && (fraction == '0);
        nan  = (exponent == '1) && (fraction != '0);
        snan = nan && !fraction[SIG_W-1];
    end

endmodule

// File: rtl/fpu_mds_seq.sv
// Controller for the FPU multiply/divide/sqrt datapath: resolves IEEE special
// cases in one cycle, otherwise sequences the multiplier or div/sqrt units.
module fpu_mds_seq
    import fpu_mds_pkg::*;
#(
    parameter int unsigned EXP_W     = 8,
    parameter int unsigned SIG_W     = 23,
    parameter int unsigned MUL_LAT   = 2,
    parameter bit          CANON_NAN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   kill,
    input  logic [1:0]             op_sel,
    input  logic                   sign_a,
    input  logic                   sign_b,
    input  logic [EXP_W-1:0]       exp_a,
    input  logic [EXP_W-1:0]       exp_b,
    input  logic [SIG_W-1:0]       sig_a,
    input  logic [SIG_W-1:0]       sig_b,
    input  logic                   div_rdy,
    input  logic                   sqrt_rdy,
    output logic                   div_start,
    output logic                   sqrt_start,
    output logic                   reg_en,
    output logic [1:0]             out_sel,
    output logic                   fast_sel,
    output logic [EXP_W+SIG_W:0]   fast_res,
    output logic                   invalid_fast,
    output logic                   divbyzero_fast,
    output logic                   done,
    output logic                   busy
);

    localparam int unsigned      W         = 1 + EXP_W + SIG_W;
    localparam logic [63:0]      CNAN_FULL = canon_nan(EXP_W, SIG_W);
    localparam logic [W-1:0]     CNAN      = CNAN_FULL[W-1:0];
    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [3:0]       CNT_INIT  = 4'(MUL_LAT - 1);

    logic a_zero, a_inf, a_nan, a_snan;
    logic b_zero, b_inf, b_nan, b_snan;

    fpu_class_unit #(.EXP_W(EXP_W), .SIG_W(SIG_W)) u_class_a (
        .exponent (exp_a),
        .fraction (sig_a),
        .zero     (a_zero),
        .inf      (a_inf),
        .nan      (a_nan),
        .snan     (a_snan)
    );

    fpu_class_unit #(.EXP_W(EXP_W), .SIG_W(SIG_W)) u_class_b (
        .exponent (exp_b),
        .fraction (sig_b),
        .zero     (b_zero),
        .inf      (b_inf),
        .nan      (b_nan),
        .snan     (b_snan)
    );

    state_e       state, state_n;
    logic [3:0]   cnt, cnt_n;
    logic         sign_o;
    logic [W-1:0] nan_res, inf_res, zero_res, fres;
    logic         is_fast, nv, dz;

    // Special-case resolution for the current operands and op_sel.
    always_comb begin
        sign_o   = sign_a ^ sign_b;
        inf_res  = {sign_o, EXP_ONES, {SIG_W{1'b0}}};
        zero_res = {sign_o, {(EXP_W + SIG_W){1'b0}}};
        // Payload propagation looks at B only when B is a real operand (not for sqrt).
        if (!CANON_NAN && a_nan)
            nan_res = {sign_a, exp_a, 1'b1, sig_a[SIG_W-2:0]};
        else if (!CANON_NAN && b_nan && op_sel != OP_SQRT)
            nan_res = {sign_b, exp_b, 1'b1, sig_b[SIG_W-2:0]};
        else
            nan_res = CNAN;

        is_fast = 1'b0;
        fres    = '0;
        nv      = 1'b0;
        dz      = 1'b0;
        case (op_sel)
            OP_MUL: begin
                if (a_nan || b_nan) begin
                    is_fast = 1'b1; fres = nan_res; nv = a_snan || b_snan;
                end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
                    is_fast = 1'b1; fres = nan_res; nv = 1'b1;
                end else if (a_zero || b_zero) begin
                    is_fast = 1'b1; fres = zero_res;
                end else if (a_inf || b_inf) begin
                    is_fast = 1'b1; fres = inf_res;
                end
            end
            OP_DIV: begin
                if (a_nan || b_nan) begin
                    is_fast = 1'b1; fres = nan_res; nv = a_snan || b_snan;
                end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                    is_fast = 1'b1; fres = nan_res; nv = 1'b1;
                end else if (a_inf) begin
                    is_fast = 1'b1; fres = inf_res;
                end else if (b_zero) begin
                    is_fast = 1'b1; fres = inf_res; dz = 1'b1;
                end else if (a_zero || b_inf) begin
                    is_fast = 1'b1; fres = zero_res;
                end
            end
            OP_SQRT: begin
                if (a_nan) begin
                    is_fast = 1'b1; fres = nan_res; nv = a_snan;
                end else if (a_zero) begin
                    is_fast = 1'b1; fres = {sign_a, {(EXP_W + SIG_W){1'b0}}};
                end else if (sign_a) begin
                    is_fast = 1'b1; fres = nan_res; nv = 1'b1;
                end else if (a_inf) begin
                    is_fast = 1'b1; fres = {1'b0, EXP_ONES, {SIG_W{1'b0}}};
                end
            end
            default: begin
                is_fast = 1'b1;
            end
        endcase
    end

    // State and multiplier latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and handshake outputs; kill suppresses every strobe in its cycle.
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        div_start      = 1'b0;
        sqrt_start     = 1'b0;
        reg_en         = 1'b0;
        out_sel        = OUT_MUL;
        fast_sel       = 1'b0;
        fast_res       = '0;
        invalid_fast   = 1'b0;
        divbyzero_fast = 1'b0;
        done           = 1'b0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                if (start && !kill) begin
                    if (is_fast) begin
                        fast_sel       = 1'b1;
                        reg_en         = 1'b1;
                        done           = 1'b1;
                        fast_res       = fres;
                        invalid_fast   = nv;
                        divbyzero_fast = dz;
                    end else begin
                        case (op_sel)
                            OP_MUL:  begin state_n = MUL; cnt_n = CNT_INIT; end
                            OP_DIV:  state_n = DIV;
                            OP_SQRT: state_n = SQRT;
                            default: state_n = IDLE;
                        endcase
                    end
                end
            end
            MUL: begin
                busy = 1'b1;
                if (kill) begin
                    state_n = IDLE; cnt_n = '0;
                end else if (cnt == '0) begin
                    reg_en = 1'b1; state_n = MUL_OUT;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            MUL_OUT: begin
                busy    = 1'b1;
                state_n = IDLE;
                if (!kill) begin
                    reg_en = 1'b1; done = 1'b1;
                end
            end
            DIV: begin
                busy    = 1'b1;
                out_sel = OUT_DIV;
                if (kill) begin
                    state_n = IDLE;
                end else if (div_rdy) begin
                    reg_en = 1'b1; state_n = DIV_OUT;
                end else begin
                    div_start = 1'b1;
                end
            end
            DIV_OUT: begin
                busy    = 1'b1;
                out_sel = OUT_DIV;
                state_n = IDLE;
                done    = !kill;
            end
            SQRT: begin
                busy    = 1'b1;
                out_sel = OUT_SQRT;
                if (kill) begin
                    state_n = IDLE;
                end else if (sqrt_rdy) begin
                    reg_en = 1'b1; state_n = SQRT_OUT;
                end else begin
                    sqrt_start = 1'b1;
                end
            end
            SQRT_OUT: begin
                busy    = 1'b1;
                out_sel = OUT_SQRT;
                state_n = IDLE;
                done    = !kill;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
